csi2_tx_frame_scheduler: RTL and testbench
==========================================

Name: csi2_tx_frame_scheduler

Overview:
Sequences the CSI-2 TX datapath: issues per-frame line requests to the upstream RAW16 line source at a programmed frame period, then tracks the datapath frame_start/frame_done status. Supports continuous or N-frame runs, start/stop control, start and frame watchdogs, and a datapath reset pulse on error. Sits between host/register control and the line source plus CSI-2 TX datapath.

Parameters:
CNT_W, 32, width of frame period and watchdog counters
FRM_W, 16, width of frame count fields
START_TIMEOUT, 4096, max cycles from line_ack to dp_frame_start
FRAME_TIMEOUT, 1048576, max cycles from dp_frame_start to dp_frame_done
RESET_CYCLES, 8, dp_reset high time after a timeout

Ports:
clk  in  1  single clock
rst  in  1  synchronous active-high reset
start  in  1  pulse: begin run (ignored while busy)
stop  in  1  pulse: end run after current frame
cfg_period  in  CNT_W  cycles between successive line_req rising edges; 0 = back-to-back
cfg_frames  in  FRM_W  frames per run; 0 = continuous
line_req  out  1  request one line from source, held until line_ack
line_ack  in  1  source accepted request
dp_frame_start  in  1  datapath frame-start pulse
dp_frame_done  in  1  datapath frame-done pulse
dp_reset  out  1  datapath reset, active-high
busy  out  1  state != IDLE
frame_pulse  out  1  one cycle per completed frame
run_done  out  1  one cycle at end of N-frame run or stop
frame_count  out  FRM_W  frames completed this run
overrun  out  1  sticky: a frame outlasted cfg_period
err_timeout  out  1  sticky: watchdog expired

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0. Stickies clear only on rst or on an accepted start.
- Clock and reset: one clock; reset is synchronous and active-high.
- States: IDLE, REQUEST, WAIT_START, ACTIVE, WAIT_PERIOD, FINISH, ERR.
- IDLE: on start, latch cfg_period and cfg_frames, clear frame_count, overrun and err_timeout, and enter REQUEST. The config inputs are not sampled again during the run.
- REQUEST: line_req=1. Period timer loads the latched period on entry, then decrements each cycle, saturating at 0. On line_ack=1 (same-cycle handshake), drop line_req next cycle, clear the watchdog, and go to WAIT_START.
- WAIT_START: on dp_frame_start, go to ACTIVE with the watchdog cleared. If the watchdog reaches START_TIMEOUT, go to ERR.
- ACTIVE: on dp_frame_done, increment frame_count (wraps at 2^FRM_W) and pulse frame_pulse. If the watchdog reaches FRAME_TIMEOUT, go to ERR.
- ACTIVE exit priority on dp_frame_done:
  1. stop pending, or latched frames != 0 and updated count == frames: go to FINISH.
  2. Otherwise go to WAIT_PERIOD.
  3. If the timer is already 0 and the latched period != 0, set overrun.
- WAIT_PERIOD: go to REQUEST when the timer reaches 0. This state is exited the cycle after entry at minimum; period 0 yields REQUEST 1 cycle after done. stop here goes to FINISH.
- stop: sets a pending flag in REQUEST, WAIT_START and ACTIVE. The current request/frame completes normally. stop in IDLE is ignored.
- FINISH: run_done=1 for one cycle, then IDLE. The pending flag clears.
- ERR:
  - err_timeout set; line_req=0.
  - dp_reset=1 for exactly RESET_CYCLES cycles, then IDLE with no run_done.
  - start is ignored during ERR.
- Simultaneous events:
  - start with stop in IDLE: start wins, stop is ignored.
  - dp_frame_done on the same cycle as watchdog expiry: done wins.
  - dp_frame_start outside WAIT_START, and dp_frame_done outside ACTIVE, are ignored.
- Latency: start to line_req = 1 cycle. line_ack to line_req low = 1 cycle.
- Watchdog: saturating counter of CNT_W bits.

Test Plan:
- cfg_period=1000, cfg_frames=3, source acks in 2 cycles, datapath frames 600 cycles: line_req rising edges 1000 cycles apart; 3 frame_pulses; run_done once; frame_count=3; overrun=0.
- cfg_period=100, frame lasting 400 cycles, cfg_frames=2: overrun=1; second line_req 1 cycle after first dp_frame_done + 1; run_done after 2 frames.
- cfg_frames=0, stop asserted mid-ACTIVE of frame 5: frame 5 completes, frame_count=5, run_done pulses, no 6th line_req.
- No dp_frame_start after line_ack: err_timeout=1 after START_TIMEOUT cycles; dp_reset high exactly 8 cycles; busy=0 afterwards; subsequent start clears err_timeout and runs normally.
- rst asserted during ACTIVE with line_req history: all outputs 0 next cycle; dp_frame_done arriving after reset produces no frame_pulse.
- start pulsed while busy, and dp_frame_done coincident with FRAME_TIMEOUT expiry: run parameters unchanged; frame counted, no error.

Source files
------------

// File: rtl/csi2_tx_frame_scheduler.sv
// CSI-2 TX frame scheduler: paces per-frame line requests at a programmed period and
// tracks datapath frame start/done, pulsing a datapath reset when a watchdog expires.
module csi2_tx_frame_scheduler #(
  parameter int CNT_W         = 32,
  parameter int FRM_W         = 16,
  parameter int START_TIMEOUT = 4096,
  parameter int FRAME_TIMEOUT = 1048576,
  parameter int RESET_CYCLES  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [FRM_W-1:0] cfg_frames,
  output logic             line_req,
  input  logic             line_ack,
  input  logic             dp_frame_start,
  input  logic             dp_frame_done,
  output logic             dp_reset,
  output logic             busy,
  output logic             frame_pulse,
  output logic             run_done,
  output logic [FRM_W-1:0] frame_count,
  output logic             overrun,
  output logic             err_timeout
);

  // state       | meaning
  // IDLE        | no run; WAIT_START | line accepted, awaiting dp_frame_start
  // REQUEST     | line_req held;     ACTIVE     | frame in flight, awaiting dp_frame_done
  // WAIT_PERIOD | pacing gap;        FINISH     | run_done pulse;  ERR | dp_reset held
  typedef enum logic [2:0] {
    IDLE, REQUEST, WAIT_START, ACTIVE, WAIT_PERIOD, FINISH, ERR
  } state_t;

  localparam int               RC_W      = $clog2(RESET_CYCLES + 1);
  localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FRAME_LIM = CNT_W'(FRAME_TIMEOUT - 1);
  localparam logic [RC_W-1:0]  RC_LOAD   = RC_W'(RESET_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] period_q, timer, wd;
  logic [FRM_W-1:0] frames_q, count_inc;
  logic [RC_W-1:0]  rst_cnt;
  logic             stop_pend, stop_now, last_frame, start_ok, done_ok;

  assign count_inc  = frame_count + FRM_W'(1);
  assign stop_now   = stop_pend | stop;
  assign last_frame = stop_now | ((frames_q != '0) && (count_inc == frames_q));
  assign start_ok   = (state == IDLE) && start;
  assign done_ok    = (state == ACTIVE) && dp_frame_done;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Watchdog and timer compares look at the value they reach on this edge, so
  // WAIT_START/ACTIVE last at most *_TIMEOUT cycles and requests are cfg_period apart.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:        if (start) state_n = REQUEST;
      REQUEST:     if (line_ack) state_n = WAIT_START;
      WAIT_START: begin
        if (dp_frame_start)      state_n = ACTIVE;
        else if (wd >= START_LIM) state_n = ERR;
      end
      ACTIVE: begin
        if (dp_frame_done)        state_n = last_frame ? FINISH : WAIT_PERIOD;
        else if (wd >= FRAME_LIM) state_n = ERR;
      end
      WAIT_PERIOD: begin
        if (stop)                        state_n = FINISH;
        else if (timer <= CNT_W'(1))     state_n = REQUEST;
      end
      FINISH:      state_n = IDLE;
      ERR:         if (rst_cnt == '0) state_n = IDLE;
      default:     state_n = IDLE;
    endcase
  end

  always_comb begin
    line_req = (state == REQUEST);
    dp_reset = (state == ERR);
    busy     = (state != IDLE);
    run_done = (state == FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q    <= '0;
      frames_q    <= '0;
      timer       <= '0;
      wd          <= '0;
      rst_cnt     <= '0;
      stop_pend   <= 1'b0;
      frame_count <= '0;
      frame_pulse <= 1'b0;
      overrun     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      frame_pulse <= 1'b0;

      if (start_ok) begin
        period_q    <= cfg_period;
        frames_q    <= cfg_frames;
        frame_count <= '0;
        overrun     <= 1'b0;
        err_timeout <= 1'b0;
      end

      if (state_n == REQUEST && state != REQUEST)
        timer <= (state == IDLE) ? cfg_period : period_q;
      else if (timer != '0)
        timer <= timer - CNT_W'(1);

      if (state_n != state)  wd <= '0;
      else if (wd != '1)     wd <= wd + CNT_W'(1);

      if (state_n == ERR && state != ERR) begin
        rst_cnt     <= RC_LOAD;
        err_timeout <= 1'b1;
      end else if (state == ERR && rst_cnt != '0) begin
        rst_cnt <= rst_cnt - RC_W'(1);
      end

      if (state == REQUEST || state == WAIT_START || state == ACTIVE) begin
        if (stop) stop_pend <= 1'b1;
      end else begin
        stop_pend <= 1'b0;
      end

      if (done_ok) begin
        frame_count <= count_inc;
        frame_pulse <= 1'b1;
        if (timer == '0 && period_q != '0) overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_csi2_tx_frame_scheduler.sv
// Directed bench for csi2_tx_frame_scheduler: scripted line source and datapath,
// a negedge monitor timestamps events, each test task checks its own results.
module tb_csi2_tx_frame_scheduler;
  localparam int CNT_W = 32;
  localparam int FRM_W = 16;
  localparam int ST    = 4096;
  localparam int FT    = 2000;
  localparam int RC    = 8;

  logic             clk = 1'b0;
  logic             rst, start, stop, line_ack, dp_frame_start, dp_frame_done;
  logic [CNT_W-1:0] cfg_period;
  logic [FRM_W-1:0] cfg_frames;
  logic             line_req, dp_reset, busy, frame_pulse, run_done, overrun, err_timeout;
  logic [FRM_W-1:0] frame_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  csi2_tx_frame_scheduler #(
    .CNT_W(CNT_W), .FRM_W(FRM_W), .START_TIMEOUT(ST),
    .FRAME_TIMEOUT(FT), .RESET_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_period(cfg_period), .cfg_frames(cfg_frames),
    .line_req(line_req), .line_ack(line_ack),
    .dp_frame_start(dp_frame_start), .dp_frame_done(dp_frame_done),
    .dp_reset(dp_reset), .busy(busy), .frame_pulse(frame_pulse),
    .run_done(run_done), .frame_count(frame_count),
    .overrun(overrun), .err_timeout(err_timeout)
  );

  // Event monitor: sampled mid-cycle, only this block writes these variables.
  int cyc = 0, rise_cnt = 0, done_cnt = 0, pulse_cnt = 0, rdone_cnt = 0, dpr_cnt = 0;
  int rise_cyc [64];
  int done_cyc [64];
  int lr_fall_cyc = 0, err_rise_cyc = 0, dpr_rise_cyc = 0, dpr_fall_cyc = 0;
  logic lr_q = 1'b0, err_q = 1'b0, dpr_q = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (line_req === 1'b1 && lr_q === 1'b0) begin
      if (rise_cnt < 64) rise_cyc[rise_cnt] = cyc;
      rise_cnt++;
    end
    if (line_req === 1'b0 && lr_q === 1'b1) lr_fall_cyc = cyc;
    lr_q = line_req;
    if (dp_frame_done === 1'b1) begin
      if (done_cnt < 64) done_cyc[done_cnt] = cyc;
      done_cnt++;
    end
    if (frame_pulse === 1'b1) pulse_cnt++;
    if (run_done === 1'b1) rdone_cnt++;
    if (dp_reset === 1'b1) dpr_cnt++;
    if (err_timeout === 1'b1 && err_q === 1'b0) err_rise_cyc = cyc;
    err_q = err_timeout;
    if (dp_reset === 1'b1 && dpr_q === 1'b0) dpr_rise_cyc = cyc;
    if (dp_reset === 1'b0 && dpr_q === 1'b1) dpr_fall_cyc = cyc;
    dpr_q = dp_reset;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded 50000 cycles");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_line_req();
    int n = 0;
    while (line_req !== 1'b1 && n < 10000) begin tick(); n++; end
    n_cmp++;
    if (n >= 10000) begin n_bad++; $display("FAIL line_req_wait: line_req=%b after %0d cycles, required 1", line_req, n); end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin tick(); n++; end
    n_cmp++;
    if (n >= bound) begin n_bad++; $display("FAIL busy_wait: busy=%b after %0d cycles, required 0", busy, n); end
  endtask

  // One frame from the source/datapath side; stop pulses at frame cycle stop_at (-1 = never).
  task automatic run_frame(input int ack_dly, input int frame_len, input int stop_at);
    wait_line_req();
    repeat (ack_dly) tick();
    line_ack = 1'b1; tick(); line_ack = 1'b0;
    dp_frame_start = 1'b1; tick(); dp_frame_start = 1'b0;
    for (int i = 0; i < frame_len; i++) begin stop = (i == stop_at); tick(); end
    stop = 1'b0;
    dp_frame_done = 1'b1; tick(); dp_frame_done = 1'b0;
  endtask

  task automatic start_run(input int period, input int frames, input logic with_stop);
    cfg_period = CNT_W'(period);
    cfg_frames = FRM_W'(frames);
    start = 1'b1; stop = with_stop;
    tick();
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    rst = 1'b1;
    repeat (3) tick();
    flags = {line_req, dp_reset, busy, frame_pulse, run_done, overrun, err_timeout};
    n_cmp++; if (flags !== 7'b0) begin n_bad++; $display("FAIL reset_flags: got %b required 0000000", flags); end
    n_cmp++; if (frame_count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d required 0", frame_count); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_n_frames();
    int r0 = rise_cnt, p0 = pulse_cnt, d0 = rdone_cnt;
    start_run(1000, 3, 1'b1);
    n_cmp++; if (line_req !== 1'b1) begin n_bad++; $display("FAIL start_latency: line_req=%b required 1", line_req); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL start_busy: busy=%b required 1", busy); end
    for (int f = 0; f < 3; f++) run_frame(2, 600, -1);
    wait_idle(50);
    n_cmp++; if (rise_cnt - r0 !== 3) begin n_bad++; $display("FAIL nf_requests: got %0d required 3", rise_cnt - r0); end
    n_cmp++; if (rise_cyc[r0+1] - rise_cyc[r0] !== 1000) begin n_bad++; $display("FAIL nf_spacing1: got %0d required 1000", rise_cyc[r0+1] - rise_cyc[r0]); end
    n_cmp++; if (rise_cyc[r0+2] - rise_cyc[r0+1] !== 1000) begin n_bad++; $display("FAIL nf_spacing2: got %0d required 1000", rise_cyc[r0+2] - rise_cyc[r0+1]); end
    n_cmp++; if (lr_fall_cyc - rise_cyc[r0+2] !== 3) begin n_bad++; $display("FAIL ack_latency: line_req high %0d cycles, required 3", lr_fall_cyc - rise_cyc[r0+2]); end
    n_cmp++; if (pulse_cnt - p0 !== 3) begin n_bad++; $display("FAIL nf_pulses: got %0d required 3", pulse_cnt - p0); end
    n_cmp++; if (rdone_cnt - d0 !== 1) begin n_bad++; $display("FAIL nf_run_done: got %0d required 1", rdone_cnt - d0); end
    n_cmp++; if (frame_count !== 16'd3) begin n_bad++; $display("FAIL nf_count: got %0d required 3", frame_count); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL nf_overrun: got %b required 0", overrun); end
  endtask

  task automatic test_overrun();
    int r0 = rise_cnt, dn0 = done_cnt, d0 = rdone_cnt;
    start_run(100, 2, 1'b0);
    run_frame(2, 400, -1);
    run_frame(2, 400, -1);
    wait_idle(50);
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ov_flag: got %b required 1", overrun); end
    n_cmp++; if (rise_cyc[r0+1] - done_cyc[dn0] !== 2) begin n_bad++; $display("FAIL ov_rerequest: got %0d cycles after done, required 2", rise_cyc[r0+1] - done_cyc[dn0]); end
    n_cmp++; if (rdone_cnt - d0 !== 1) begin n_bad++; $display("FAIL ov_run_done: got %0d required 1", rdone_cnt - d0); end
    n_cmp++; if (frame_count !== 16'd2) begin n_bad++; $display("FAIL ov_count: got %0d required 2", frame_count); end
  endtask

  task automatic test_stop_continuous();
    int r0 = rise_cnt, p0 = pulse_cnt, d0 = rdone_cnt;
    start_run(0, 0, 1'b0);
    for (int f = 0; f < 4; f++) run_frame(1, 20, -1);
    run_frame(1, 20, 10);
    repeat (30) tick();
    n_cmp++; if (rise_cnt - r0 !== 5) begin n_bad++; $display("FAIL stop_requests: got %0d required 5", rise_cnt - r0); end
    n_cmp++; if (frame_count !== 16'd5) begin n_bad++; $display("FAIL stop_count: got %0d required 5", frame_count); end
    n_cmp++; if (pulse_cnt - p0 !== 5) begin n_bad++; $display("FAIL stop_pulses: got %0d required 5", pulse_cnt - p0); end
    n_cmp++; if (rdone_cnt - d0 !== 1) begin n_bad++; $display("FAIL stop_run_done: got %0d required 1", rdone_cnt - d0); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stop_busy: got %b required 0", busy); end
  endtask

  task automatic test_start_timeout();
    int r0 = rise_cnt, d0 = rdone_cnt, pr0 = dpr_cnt, n = 0;
    start_run(0, 1, 1'b0);
    wait_line_req();
    line_ack = 1'b1; tick(); line_ack = 1'b0;
    while (err_timeout !== 1'b1 && n < ST + 100) begin tick(); n++; end
    n_cmp++; if (n >= ST + 100) begin n_bad++; $display("FAIL st_wait: err_timeout=%b after %0d cycles, required 1", err_timeout, n); end
    start = 1'b1; tick(); start = 1'b0;
    wait_idle(50);
    repeat (3) tick();
    n_cmp++; if (err_rise_cyc - lr_fall_cyc !== ST) begin n_bad++; $display("FAIL st_delay: got %0d cycles required %0d", err_rise_cyc - lr_fall_cyc, ST); end
    n_cmp++; if (dpr_fall_cyc - dpr_rise_cyc !== RC) begin n_bad++; $display("FAIL st_dp_reset_len: got %0d required %0d", dpr_fall_cyc - dpr_rise_cyc, RC); end
    n_cmp++; if (dpr_cnt - pr0 !== RC) begin n_bad++; $display("FAIL st_dp_reset_total: got %0d required %0d", dpr_cnt - pr0, RC); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL st_busy: got %b required 0", busy); end
    n_cmp++; if (err_timeout !== 1'b1) begin n_bad++; $display("FAIL st_sticky: got %b required 1", err_timeout); end
    n_cmp++; if (rdone_cnt - d0 !== 0) begin n_bad++; $display("FAIL st_no_run_done: got %0d required 0", rdone_cnt - d0); end
    n_cmp++; if (rise_cnt - r0 !== 1) begin n_bad++; $display("FAIL st_err_start_ignored: got %0d requests required 1", rise_cnt - r0); end
    d0 = rdone_cnt;
    start_run(0, 1, 1'b0);
    n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL st_clear: got %b required 0", err_timeout); end
    run_frame(1, 30, -1);
    wait_idle(50);
    n_cmp++; if (frame_count !== 16'd1) begin n_bad++; $display("FAIL st_rerun_count: got %0d required 1", frame_count); end
    n_cmp++; if (rdone_cnt - d0 !== 1) begin n_bad++; $display("FAIL st_rerun_done: got %0d required 1", rdone_cnt - d0); end
  endtask

  task automatic test_reset_active();
    logic [6:0] flags;
    int p0;
    start_run(5, 0, 1'b0);
    run_frame(1, 30, -1);
    wait_line_req();
    line_ack = 1'b1; tick(); line_ack = 1'b0;
    dp_frame_start = 1'b1; tick(); dp_frame_start = 1'b0;
    repeat (10) tick();
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ra_pre_overrun: got %b required 1", overrun); end
    n_cmp++; if (frame_count !== 16'd1) begin n_bad++; $display("FAIL ra_pre_count: got %0d required 1", frame_count); end
    rst = 1'b1; tick(); rst = 1'b0;
    flags = {line_req, dp_reset, busy, frame_pulse, run_done, overrun, err_timeout};
    n_cmp++; if (flags !== 7'b0) begin n_bad++; $display("FAIL ra_flags: got %b required 0000000", flags); end
    n_cmp++; if (frame_count !== '0) begin n_bad++; $display("FAIL ra_count: got %0d required 0", frame_count); end
    p0 = pulse_cnt;
    dp_frame_done = 1'b1; tick(); dp_frame_done = 1'b0;
    repeat (2) tick();
    n_cmp++; if (pulse_cnt - p0 !== 0) begin n_bad++; $display("FAIL ra_no_pulse: got %0d required 0", pulse_cnt - p0); end
    n_cmp++; if (frame_count !== '0) begin n_bad++; $display("FAIL ra_post_count: got %0d required 0", frame_count); end
  endtask

  task automatic test_busy_start_and_done_at_expiry();
    int r0 = rise_cnt, d0 = rdone_cnt;
    start_run(2100, 2, 1'b0);
    tick();
    cfg_period = CNT_W'(10); cfg_frames = FRM_W'(5);
    start = 1'b1; tick(); start = 1'b0;
    run_frame(2, FT - 1, -1);
    n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL ex_done_wins: err_timeout=%b required 0", err_timeout); end
    n_cmp++; if (frame_count !== 16'd1) begin n_bad++; $display("FAIL ex_count1: got %0d required 1", frame_count); end
    run_frame(2, 50, -1);
    wait_idle(2200);
    n_cmp++; if (rise_cnt - r0 !== 2) begin n_bad++; $display("FAIL ex_requests: got %0d required 2", rise_cnt - r0); end
    n_cmp++; if (rise_cyc[r0+1] - rise_cyc[r0] !== 2100) begin n_bad++; $display("FAIL ex_spacing: got %0d required 2100", rise_cyc[r0+1] - rise_cyc[r0]); end
    n_cmp++; if (rdone_cnt - d0 !== 1) begin n_bad++; $display("FAIL ex_run_done: got %0d required 1", rdone_cnt - d0); end
    n_cmp++; if (frame_count !== 16'd2) begin n_bad++; $display("FAIL ex_count2: got %0d required 2", frame_count); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ex_overrun: got %b required 0", overrun); end
    n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL ex_err: got %b required 0", err_timeout); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; line_ack = 1'b0;
    dp_frame_start = 1'b0; dp_frame_done = 1'b0;
    cfg_period = '0; cfg_frames = '0;
    test_reset();
    test_n_frames();
    test_overrun();
    test_stop_continuous();
    test_start_timeout();
    test_reset_active();
    test_busy_start_and_done_at_expiry();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
